// File: rtl/sw_pkg.sv
// Shared constants and types for the slide-switch conditioning path.
package sw_pkg;

  localparam int unsigned SW_DEBOUNCE_DEFAULT = 500000;
  localparam int unsigned SW_WIDTH_DEFAULT    = 3;
  localparam int unsigned SW_DEBOUNCE_SIM     = 4;

  // Per-channel state, derived each cycle from the synchronized input vs. the accepted level.
  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchronizer, stability counter, debounced level and edge pulses.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, q, r, f;
  logic [CW-1:0] cnt;
  ch_state_t     st;

  always_comb begin
    st = (s2 == q) ? CH_IDLE : CH_PENDING;
  end

  // Any cycle back at the accepted level drops the partial count, so a bounce restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      q   <= 1'b0;
      r   <= 1'b0;
      f   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      r  <= 1'b0;
      f  <= 1'b0;
      case (st)
        CH_IDLE: cnt <= '0;
        CH_PENDING: begin
          if (cnt == CMAX) begin
            q   <= s2;
            r   <= s2;
            f   <= ~s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign dout = q;
  assign rise = r;
  assign fall = f;

endmodule

// File: rtl/sw_debounce.sv
// Multi-bit switch conditioner: WIDTH independent debounce channels side by side.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .din  (sw_in[i]),
      .dout (sw_out[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with WIDTH=3, DEBOUNCE_CYCLES=4.
module tb_sw_debounce;
  import sw_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  out;
    logic [2:0]  rise;
    logic [2:0]  fall;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw_in = 3'b000;
  logic [2:0] sw_out, sw_rise, sw_fall;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         sbq[$];
  logic [2:0]  exp_out = 3'b000;

  sw_debounce #(
    .WIDTH(SW_WIDTH_DEFAULT),
    .DEBOUNCE_CYCLES(SW_DEBOUNCE_SIM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 2 time units into the cycle.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // An input change made now is captured at edge cyc+1; outputs update at edge cyc+6.
  task automatic expect_ev(input logic [2:0] o, input logic [2:0] r, input logic [2:0] f);
    ev_t e;
    e.cyc  = cyc + 6;
    e.out  = o;
    e.rise = r;
    e.fall = f;
    sbq.push_back(e);
  endtask

  // Monitor: every pulse must match the next scoreboard entry; otherwise sw_out must hold.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_out = 3'b000;
        chk("rst_out", {29'd0, sw_out}, 32'd0);
        chk("rst_pulses", {26'd0, sw_rise, sw_fall}, 32'd0);
      end else if ((sw_rise | sw_fall) != 3'b000) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {26'd0, sw_rise, sw_fall}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("ev_cycle", e.cyc, cyc);
          chk("ev_out", {29'd0, sw_out}, {29'd0, e.out});
          chk("ev_rise", {29'd0, sw_rise}, {29'd0, e.rise});
          chk("ev_fall", {29'd0, sw_fall}, {29'd0, e.fall});
          exp_out = e.out;
        end
      end else begin
        chk("out_hold", {29'd0, sw_out}, {29'd0, exp_out});
      end
    end
  end

  initial begin
    // Power-on reset
    step(3);
    chk("por_out", {29'd0, sw_out}, 32'd0);
    rst = 1'b0;
    step(2);

    // Clean step on bit 0
    sw_in = 3'b001;
    expect_ev(3'b001, 3'b001, 3'b000);
    step(10);

    // Bounce on bit 1, then hold 1
    for (int unsigned i = 0; i < 6; i++) begin
      sw_in[1] = ~i[0];
      step(1);
    end
    sw_in[1] = 1'b1;
    expect_ev(3'b011, 3'b010, 3'b000);
    step(12);

    // Three-clock glitch on bit 2: must be rejected
    sw_in[2] = 1'b1;
    step(3);
    sw_in[2] = 1'b0;
    step(10);
    chk("glitch_out", {29'd0, sw_out}, 32'h3);

    // Settle to 111, then drop all bits together
    sw_in = 3'b111;
    expect_ev(3'b111, 3'b100, 3'b000);
    step(10);
    sw_in = 3'b000;
    expect_ev(3'b000, 3'b000, 3'b111);
    step(10);

    // Asynchronous reset from a settled 111
    sw_in = 3'b111;
    expect_ev(3'b111, 3'b111, 3'b000);
    step(10);
    chk("pre_rst_out", {29'd0, sw_out}, 32'h7);
    rst = 1'b1;
    #1;
    chk("async_rst_out", {29'd0, sw_out}, 32'd0);
    chk("async_rst_rise", {29'd0, sw_rise}, 32'd0);
    chk("async_rst_fall", {29'd0, sw_fall}, 32'd0);
    step(2);
    rst = 1'b0;
    expect_ev(3'b111, 3'b111, 3'b000);
    step(10);

    // Reset while bit 0 is pending with cnt=2
    sw_in = 3'b000;
    expect_ev(3'b000, 3'b000, 3'b111);
    step(10);
    sw_in = 3'b001;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_ev(3'b001, 3'b001, 3'b000);
    step(10);

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Multi-bit switch conditioner that sits directly upstream of the board-level logic gates: it takes raw, bouncing, asynchronous slide-switch inputs and delivers clean, clock-synchronous levels plus single-cycle edge pulses. Its `sw_out` bits drive gate inputs such as the 3-input XOR on `sw[5:3]`. Each bit has a two-flop synchronizer followed by a stability counter. A bit's output changes only after its input has held a new value for `DEBOUNCE_CYCLES` consecutive clocks.

## Interface
- `WIDTH`, default 3: number of independent switch channels.
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles required before accepting a change. Legal range is ≥ 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`, derived internally.
- `clk` in 1: the single system clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sw_in` in `WIDTH`: raw switch levels, asynchronous to `clk`.
- `sw_out` out `WIDTH`: debounced, registered switch levels.
- `sw_rise` out `WIDTH`: one-cycle pulse when the corresponding `sw_out` bit goes 0→1.
- `sw_fall` out `WIDTH`: one-cycle pulse when the corresponding `sw_out` bit goes 1→0.

## Operation
- Channels are fully independent. There is no shared counter and no cross-channel coupling.
- Each channel holds the following registers:
  - synchronizer pair `s1`, `s2`;
  - stability counter `cnt`;
  - debounced level `q`, which drives `sw_out`;
  - edge registers `r` and `f`.
- Each channel has two implicit states, selected by comparing `s2` with `q`:
  - IDLE: `s2 == q`. `cnt` is held at 0. `r` and `f` are 0.
  - PENDING: `s2 != q`.
    - If `cnt < DEBOUNCE_CYCLES-1`, `cnt` increments.
    - If `cnt == DEBOUNCE_CYCLES-1`, then on that edge `q <= s2`, `cnt <= 0`, and exactly one of `r` or `f` is set for one cycle according to the new `q`. The channel returns to IDLE.
- Bounce handling:
  - Any cycle in which `s2 == q` while PENDING returns the channel to IDLE and clears `cnt` to 0. Partial counts are never retained.
  - A bounce back to the old level therefore restarts the full window.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`. No wrap-around is possible.
- `sw_rise` and `sw_fall` are never both high for the same bit. Each pulse coincides with the first cycle of the new `sw_out` value.
- Reset, whenever asserted:
  - All `s1`, `s2`, `cnt`, `q`, `r` and `f` clear immediately.
  - Outputs are therefore `sw_out = 0`, `sw_rise = 0`, `sw_fall = 0`.
  - A pending count is discarded.
- After reset deasserts with a switch held at 1, that bit follows the normal 0→1 path: `sw_out` rises after the full latency and one `sw_rise` pulse is emitted.

## Timing
- Let edge k be the first rising edge at which `s1` samples a new, then-stable `sw_in` value.
  - `s2` takes the value at edge k+1.
  - `cnt` is 1 after edge k+2 and `DEBOUNCE_CYCLES-1` after edge k+`DEBOUNCE_CYCLES`.
  - `sw_out` and the edge pulse update at edge k+`DEBOUNCE_CYCLES`+1.
- Total latency from the capture edge is therefore `DEBOUNCE_CYCLES`+1 clocks. This is exact, not a bound.
- Pulse width is exactly one clock period.
- An input pulse shorter than `DEBOUNCE_CYCLES` clocks at `s2` produces no output change and no pulse.
- Simultaneous changes on several bits are processed in parallel with identical latency.
- No combinational path exists from `sw_in` to any output. All outputs are registers.

## Structure
- Shared package `sw_pkg`:
  - `SW_DEBOUNCE_DEFAULT` (500000);
  - `SW_WIDTH_DEFAULT` (3);
  - a simulation constant `SW_DEBOUNCE_SIM` (4).
- One sub-module, `debounce_bit`: a single channel containing the synchronizer, counter, `q`, `r` and `f`, parameterized by `DEBOUNCE_CYCLES`.
- `sw_debounce` instantiates `WIDTH` copies of `debounce_bit` in a generate loop and concatenates their outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `WIDTH=3`.
- Reset: assert `rst` mid-cycle with `sw_in=3'b111` → all outputs 0 immediately, asynchronously. Release → `sw_out` becomes 3'b111 at edge k+5, with `sw_rise=3'b111` for exactly one cycle.
- Clean step: bit 0 goes 0→1 and holds → `sw_out[0]=1` exactly 5 edges after the capture edge; `sw_rise[0]` high for one cycle; `sw_fall` stays 0.
- Bounce: bit 1 toggles 1,0,1,0 every clock for 6 cycles, then holds 1 → no output change during bouncing; `sw_out[1]` rises 5 edges after the final stable capture.
- Short glitch: bit 2 is high for 3 clocks, then low → `sw_out[2]`, `sw_rise[2]` and `sw_fall[2]` never assert.
- Simultaneous: all three bits go 1→0 on the same cycle from a settled 3'b111 → `sw_out=3'b000` on the same edge, with `sw_fall=3'b111` for one cycle.
- Reset mid-count: bit 0 is PENDING with `cnt=2` when `rst` pulses → count is discarded; after release, the full 5-edge latency applies again.
